// File: rtl/calc_cmd_driver.sv
// Registered command front end for the 4-bit signed calculator.
// Ports: cmd_* in (valid/ready), calc_* to/from calculator, res_* out (valid/ready), acc/acc_clr, ovf_cnt.
module calc_cmd_driver #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_use_acc,
  output logic [2:0]       calc_op,
  output logic [3:0]       calc_a,
  output logic [3:0]       calc_b,
  input  logic [3:0]       calc_r,
  input  logic             calc_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_r,
  output logic             res_ovf,
  output logic [3:0]       acc,
  input  logic             acc_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       alive;
  logic       accept;
  logic       capture;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid && alive) begin
          accept   = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) begin
          capture  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // cmd_ready stays low until the first edge after reset release
  assign cmd_ready = alive && (state == IDLE);
  assign res_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alive <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      alive <= 1'b1;
      if (accept) cnt <= CNT_INIT;
      else if (state == DRIVE && !capture) cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_op <= 3'd0;
      calc_a  <= 4'd0;
      calc_b  <= 4'd0;
    end else if (accept) begin
      calc_op <= cmd_op;
      calc_b  <= cmd_b;
      calc_a  <= cmd_use_acc ? acc : cmd_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r   <= 4'd0;
      res_ovf <= 1'b0;
    end else if (capture) begin
      res_r   <= calc_r;
      res_ovf <= calc_ovf;
    end
  end

  // capture has priority over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= 4'd0;
    else if (capture) acc <= calc_r;
    else if (acc_clr) acc <= 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt <= '0;
    else if (capture && calc_ovf && !(&ovf_cnt))
      ovf_cnt <= ovf_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Scoreboard bench for calc_cmd_driver with a glitching calculator model.
// Ports: drives every DUT port; SETTLE=3, CNT_W=3 to reach saturation.
module tb_calc_cmd_driver;

  localparam int S  = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [3:0]    cmd_a;
  logic [3:0]    cmd_b;
  logic          cmd_use_acc;
  logic [2:0]    calc_op;
  logic [3:0]    calc_a;
  logic [3:0]    calc_b;
  logic [3:0]    calc_r;
  logic          calc_ovf;
  logic          res_valid;
  logic          res_ready;
  logic [3:0]    res_r;
  logic          res_ovf;
  logic [3:0]    acc;
  logic          acc_clr;
  logic [CW-1:0] ovf_cnt;
  logic [3:0]    glitch;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]    r;
    logic          ovf;
    logic [3:0]    acc;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  logic [3:0]    acc_m;
  logic [CW-1:0] cnt_m;

  calc_cmd_driver #(.SETTLE(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
    .calc_r(calc_r), .calc_ovf(calc_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_r(res_r), .res_ovf(res_ovf),
    .acc(acc), .acc_clr(acc_clr), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // calculator: {ovf, r} from signed arithmetic on the opcode table
  function automatic logic [4:0] calc(
    input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, v;
    logic [4:0] o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'd0: v = sa + sb;
      3'd1: v = sa - sb;
      3'd2, 3'd3: v = (sb < 0) ? -sb : sb;
      3'd4: v = sb + sa;
      3'd5: v = sb - sa;
      default: v = (sa < 0) ? -sa : sa;
    endcase
    o[3:0] = v[3:0];
    o[4]   = (v > 7) || (v < -8);
    return o;
  endfunction

  // glitch corrupts the calculator output outside the capture window
  assign {calc_ovf, calc_r} =
    calc(calc_op, calc_a, calc_b) ^ {glitch[0], glitch};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_res", 1, 0);
      end else begin
        chk("res_r", int'(res_r), int'(q[0].r));
        chk("res_ovf", int'(res_ovf), int'(q[0].ovf));
        chk("acc_cap", int'(acc), int'(q[0].acc));
        chk("ovf_cnt", int'(ovf_cnt), int'(q[0].cnt));
        if (res_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic use_acc,
                      input logic clr, input int bp);
    logic [3:0] opa;
    logic [4:0] o;
    exp_t e;
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    chk("acc_pre", int'(acc), int'(acc_m));
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
    acc_clr     = clr;
    opa = use_acc ? acc_m : a;
    o   = calc(op, opa, b);
    acc_m = o[3:0];
    if (o[4] && cnt_m != '1) cnt_m++;
    e.r = o[3:0]; e.ovf = o[4]; e.acc = acc_m; e.cnt = cnt_m;
    q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("calc_op", int'(calc_op), int'(op));
    chk("calc_a", int'(calc_a), int'(opa));
    chk("calc_b", int'(calc_b), int'(b));
    chk("busy_ready", int'(cmd_ready), 0);
    glitch = 4'($urandom_range(1, 15));
    repeat (S - 2) begin
      @(posedge clk); #1;
      glitch = 4'($urandom_range(1, 15));
    end
    @(posedge clk); #1;
    glitch = 4'd0;
    chk("early_valid", int'(res_valid), 0);
    @(posedge clk); #1;
    acc_clr = 1'b0;
    chk("res_valid", int'(res_valid), 1);
    res_ready = 1'b0;
    repeat (bp) begin
      cmd_valid = 1'b1;
      cmd_op = 3'($urandom);
      @(posedge clk); #1;
      chk("bp_valid", int'(res_valid), 1);
      chk("bp_ready", int'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_valid", int'(res_valid), 0);
    chk("idle_ready", int'(cmd_ready), 1);
  endtask

  task automatic clr_pulse();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    acc_m = 4'd0;
    chk("acc_clr", int'(acc), 0);
  endtask

  task automatic mid_reset();
    cmd_valid = 1'b1;
    cmd_op = 3'd0; cmd_a = 4'd1; cmd_b = 4'd1; cmd_use_acc = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_state", int'({calc_op, calc_a, calc_b, res_valid,
                           res_r, res_ovf, acc, cmd_ready}), 0);
    chk("rst_cnt", int'(ovf_cnt), 0);
    acc_m = 4'd0;
    cnt_m = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_ready", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("post_ready", int'(cmd_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0;
    cmd_use_acc = 1'b0; res_ready = 1'b0; acc_clr = 1'b0;
    glitch = 4'd0; acc_m = 4'd0; cnt_m = '0;
    #1;
    chk("reset_out", int'({calc_op, calc_a, calc_b, res_valid,
                           res_r, res_ovf, acc, cmd_ready}), 0);
    chk("reset_cnt", int'(ovf_cnt), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_up", int'(cmd_ready), 1);

    send(3'd0, 4'd3, 4'd4, 1'b0, 1'b0, 0);
    send(3'd1, 4'd0, 4'd2, 1'b1, 1'b0, 0);
    clr_pulse();
    send(3'd0, 4'd5, 4'd4, 1'b0, 1'b0, 5);
    send(3'd4, 4'd0, 4'd3, 1'b1, 1'b1, 0);
    mid_reset();
    send(3'd7, 4'd8, 4'd0, 1'b0, 1'b0, 1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) clr_pulse();
      send(3'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3));
    end
    for (int i = 0; i < 9; i++)
      send(3'd0, 4'd7, 4'd7, 1'b0, 1'b0, 0);
    chk("sat_cnt", int'(ovf_cnt), (1 << CW) - 1);

    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_cmd_driver.md
# calc_cmd_driver

Sequential front end for the team's 4-bit signed combinational calculator. Accepts operation commands over a valid/ready handshake and drives registered opcode/operand values into the calculator. It holds them for a programmable settle time, then captures the result and overflow flag and returns them over a second valid/ready handshake. Keeps a 4-bit accumulator for chained operations and a saturating overflow-event counter.

## Interface
Parameters:
- SETTLE, 1: cycles calc_* are held stable before the result is sampled; legal range 1..15.
- CNT_W, 8: width of ovf_cnt.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_op  in  3  opcode: 000 A+B, 001 A−B, 01x abs(B), 100 B+A, 101 B−A, 11x abs(A).
- cmd_a  in  4  signed operand A; ignored when cmd_use_acc=1.
- cmd_b  in  4  signed operand B.
- cmd_use_acc  in  1  1 = use accumulator as operand A.
- calc_op  out  3  registered opcode to calculator.
- calc_a, calc_b  out  4 each  registered signed operands to calculator.
- calc_r  in  4  calculator result (combinational from calc_*).
- calc_ovf  in  1  calculator overflow flag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_r  out  4  captured signed result.
- res_ovf  out  1  captured overflow.
- acc  out  4  accumulator value.
- acc_clr  in  1  synchronous accumulator clear.
- ovf_cnt  out  CNT_W  count of captured results with ovf=1; saturates at all-ones.

## Operation
- FSM states: IDLE, DRIVE, RESP.
- IDLE: cmd_ready=1. On cmd_valid: load calc_op←cmd_op, calc_b←cmd_b, calc_a←(cmd_use_acc ? acc : cmd_a); load settle counter←SETTLE−1; go to DRIVE.
- DRIVE: cmd_ready=0; calc_* held constant. Counter decrements each cycle. When counter=0: res_r←calc_r, res_ovf←calc_ovf, acc←calc_r, and ovf_cnt increments if calc_ovf=1 (unless saturated); go to RESP.
- RESP: res_valid=1; res_r/res_ovf are stable. On res_ready, clear res_valid and go to IDLE. calc_* keep their last values.
- The driver performs no arithmetic; all results come from calc_r/calc_ovf.
- Accumulator: 4-bit two's complement, no saturation; the captured value is stored as-is, including on overflow.
- acc_clr: sets acc to 0 next cycle. If asserted in the capture cycle, capture wins. An operand sampled with cmd_use_acc in the same cycle as acc_clr uses the pre-clear acc.
- ovf_cnt is never cleared except by reset.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; cmd_ready=0 while in reset, 1 from the first edge after release. calc_op=000, calc_a=0, calc_b=0, res_valid=0, res_r=0, res_ovf=0, acc=0, ovf_cnt=0.
- Accept at edge E0 (cmd_valid & cmd_ready). calc_* are valid after E0. Capture occurs at edge E0+SETTLE. res_valid is high after E0+SETTLE.
- Minimum command-to-result latency is SETTLE+1 cycles. Throughput is one command per SETTLE+2 cycles with res_ready held high.
- res_ready is ignored outside RESP. cmd_valid is ignored outside IDLE; the command holds until accepted.
- Reset mid-DRIVE or mid-RESP abandons the operation: no result is emitted, and acc and ovf_cnt return to 0.
- ovf_cnt at all-ones stays at all-ones on further overflow captures.

## Test plan
- Basic add: cmd_op=000, a=3, b=4, SETTLE=1, calculator model returns 7/ovf0. Require calc_*=(000,3,4) one cycle after accept, res_valid 2 cycles after accept with res_r=7, res_ovf=0, acc=7.
- Overflow: op=000, a=5, b=4; model returns −7/ovf1. Require res_r=−7 (1001), res_ovf=1, ovf_cnt=1, acc=−7.
- Chained accumulator: after acc=7, send op=001, use_acc=1, b=2. Require calc_a=7 and acc=5 after capture. Then pulse acc_clr and require acc=0 next cycle.
- Backpressure: hold res_ready=0 for 5 cycles. Require res_valid, res_r and res_ovf stable, cmd_ready=0, and a waiting cmd_valid not accepted. Raise res_ready and require IDLE next cycle, then accept.
- SETTLE=3: change the model output during DRIVE. Require capture of the value present at accept+3 only.
- Reset mid-DRIVE: drop rst_n one cycle after accept. Require all outputs to reach reset values immediately, no res_valid, and normal operation after release.
